// File: rtl/pwm_wave_gen.sv
// Single-channel waveform generator: square, PWM and counted-burst output,
// with period/duty/mode shadowed at every period boundary.
module pwm_wave_gen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   duty,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               start,
    output logic               wave,
    output logic               period_tick,
    output logic               busy,
    output logic               cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;

    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_SQUARE = 2'd1;
    localparam logic [1:0] M_PWM    = 2'd2;
    localparam logic [1:0] M_BURST  = 2'd3;

    localparam logic [CNT_W-1:0]   ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   TWO  = CNT_W'(2);
    localparam logic [BURST_W-1:0] BONE = BURST_W'(1);

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [CNT_W-1:0]   pReg, pNext;
    logic [CNT_W-1:0]   dReg, dNext;
    logic [CNT_W-1:0]   hNext;
    logic [1:0]         modeQ, modeNext;
    logic [BURST_W-1:0] bcnt, bcntNext;
    logic               load;
    logic               boundary;
    logic               cfgErrNext;

    // Next-state, shadow-load and high-time computation
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        bcntNext   = bcnt;
        load       = 1'b0;
        cfgErrNext = 1'b0;
        boundary   = (cnt == pReg - ONE);

        if (!enable) begin
            stateNext = IDLE;
            cntNext   = '0;
            bcntNext  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mode == M_SQUARE || mode == M_PWM) begin
                        stateNext = RUN;
                        load      = 1'b1;
                    end else if (mode == M_BURST && start) begin
                        if (burst_len != '0) begin
                            stateNext = BURST;
                            load      = 1'b1;
                            bcntNext  = burst_len;
                        end else begin
                            cfgErrNext = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (boundary) begin
                        if (mode == M_OFF || mode == M_BURST) begin
                            stateNext = IDLE;
                            cntNext   = '0;
                        end else begin
                            load = 1'b1;
                        end
                    end else begin
                        cntNext = cnt + ONE;
                    end
                end
                BURST: begin
                    if (boundary) begin
                        if (bcnt == BONE) begin
                            stateNext = IDLE;
                            cntNext   = '0;
                            bcntNext  = '0;
                        end else begin
                            bcntNext = bcnt - BONE;
                            load     = 1'b1;
                        end
                    end else begin
                        cntNext = cnt + ONE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end

        if (load) begin
            cntNext    = '0;
            cfgErrNext = (period < TWO);
        end

        pNext    = load ? ((period < TWO) ? TWO : period) : pReg;
        dNext    = load ? duty : dReg;
        modeNext = load ? mode : modeQ;

        // Square uses half the period; PWM and burst clamp duty to the period
        if (stateNext == RUN && modeNext == M_SQUARE) begin
            hNext = pNext >> 1;
        end else if (dNext > pNext) begin
            hNext = pNext;
        end else begin
            hNext = dNext;
        end
    end

    // Outputs are registered from next-state values so they line up with cnt
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pReg        <= '0;
            dReg        <= '0;
            modeQ       <= M_OFF;
            bcnt        <= '0;
            wave        <= 1'b0;
            period_tick <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            pReg        <= pNext;
            dReg        <= dNext;
            modeQ       <= modeNext;
            bcnt        <= bcntNext;
            wave        <= (stateNext != IDLE) && (cntNext < hNext);
            period_tick <= (stateNext != IDLE) && (cntNext == pNext - ONE);
            busy        <= (stateNext != IDLE);
            cfg_err     <= cfgErrNext;
        end
    end

endmodule

// File: tb/tb_pwm_wave_gen.sv
// Bench for pwm_wave_gen: per-cycle comparison against a period-level model
// plus directed literal expectations for each waveform scenario.
module tb_pwm_wave_gen;

    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   duty;
    logic [BURST_W-1:0] burst_len;
    logic               start;
    logic               wave;
    logic               period_tick;
    logic               busy;
    logic               cfg_err;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;

    pwm_wave_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .mode(mode),
        .period(period),
        .duty(duty),
        .burst_len(burst_len),
        .start(start),
        .wave(wave),
        .period_tick(period_tick),
        .busy(busy),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Model: an active flag, position within the current period, the period's
    // length and high time, and how many burst periods remain
    bit mAct = 0, mBurst = 0;
    int mPos = 0, mP = 0, mH = 0, mLeft = 0;
    bit mWave = 0, mTick = 0, mBusy = 0, mErr = 0;

    always @(posedge clk) begin : model
        int p, h, pos, left, cP;
        bit act, brst, err, begin_p;
        p = mP; h = mH; pos = mPos; left = mLeft;
        act = mAct; brst = mBurst; err = 0; begin_p = 0;
        cP = (int'(period) < 2) ? 2 : int'(period);
        if (reset) begin
            act = 0; brst = 0; pos = 0; p = 0; h = 0; left = 0;
        end else if (!enable) begin
            act = 0; brst = 0; pos = 0;
        end else if (!act) begin
            if (mode == 2'd1 || mode == 2'd2) begin
                act = 1; brst = 0; begin_p = 1;
            end else if (mode == 2'd3 && start) begin
                if (burst_len == 0) err = 1;
                else begin
                    act = 1; brst = 1; left = int'(burst_len); begin_p = 1;
                end
            end
        end else if (pos == p - 1) begin
            if (brst) begin
                left = left - 1;
                if (left == 0) begin act = 0; brst = 0; pos = 0; end
                else begin_p = 1;
            end else if (mode == 2'd0 || mode == 2'd3) begin
                act = 0; pos = 0;
            end else begin_p = 1;
        end else begin
            pos = pos + 1;
        end
        if (begin_p) begin
            p = cP;
            h = (!brst && mode == 2'd1) ? cP / 2 : ((int'(duty) < cP) ? int'(duty) : cP);
            pos = 0;
            err = (int'(period) < 2);
        end
        mP <= p; mH <= h; mPos <= pos; mLeft <= left;
        mAct <= act; mBurst <= brst;
        mWave <= act && (pos < h);
        mTick <= act && (pos == p - 1);
        mBusy <= act;
        mErr  <= err;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input logic [1:0] md, input int per,
                                 input int dt, input int bl, input bit st);
        enable    = en;
        mode      = md;
        period    = CNT_W'(per);
        duty      = CNT_W'(dt);
        burst_len = BURST_W'(bl);
        start     = st;
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("model_wave", int'(wave), int'(mWave));
            checkOutput("model_tick", int'(period_tick), int'(mTick));
            checkOutput("model_busy", int'(busy), int'(mBusy));
            checkOutput("model_err", int'(cfg_err), int'(mErr));
        end
    end

    initial begin
        logic [7:0] sqWave;
        logic [7:0] sqTick;
        logic [4:0] sq5;
        int hi, bz;
        sqWave = 8'b1100_1100;
        sqTick = 8'b0001_0001;
        sq5    = 5'b11000;

        reset = 1'b1;
        applyStimulus(1, 2'd2, 10, 3, 2, 1);
        @(posedge clk);
        checkOn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_wave", int'(wave), 0);
            checkOutput("reset_busy", int'(busy), 0);
            checkOutput("reset_err", int'(cfg_err), 0);
        end
        reset = 1'b0;

        $display("[TB] square period 4");
        applyStimulus(1, 2'd1, 4, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("sq4_wave", int'(wave), int'(sqWave[7-i]));
            checkOutput("sq4_tick", int'(period_tick), int'(sqTick[7-i]));
        end
        repeat (2) @(negedge clk);
        applyStimulus(0, 2'd1, 4, 0, 0, 0);
        @(negedge clk);
        checkOutput("drop_wave", int'(wave), 0);
        checkOutput("drop_busy", int'(busy), 0);

        $display("[TB] square period 5");
        applyStimulus(1, 2'd1, 5, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("sq5_wave", int'(wave), int'(sq5[4-i]));
        end
        applyStimulus(0, 2'd1, 5, 0, 0, 0);
        @(negedge clk);

        $display("[TB] pwm duty change");
        applyStimulus(1, 2'd2, 10, 3, 0, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hi += int'(wave);
            if (i == 4) duty = CNT_W'(7);
        end
        checkOutput("pwm_hi_d3", hi, 3);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hi += int'(wave);
            if (i == 4) duty = CNT_W'(12);
        end
        checkOutput("pwm_hi_d7", hi, 7);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hi += int'(wave);
        end
        checkOutput("pwm_hi_d12", hi, 10);

        $display("[TB] mode off finishes period");
        repeat (2) @(negedge clk);
        mode = 2'd0;
        bz = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bz += int'(busy);
        end
        checkOutput("off_busy_tail", bz, 8);
        @(negedge clk);
        checkOutput("off_idle", int'(busy), 0);

        $display("[TB] burst of three");
        applyStimulus(1, 2'd3, 6, 2, 3, 1);
        hi = 0;
        bz = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            hi += int'(wave);
            bz += int'(busy);
            if (i == 0 || i == 8) start = 1'b0;
            if (i == 7) start = 1'b1;
        end
        checkOutput("burst_wave_hi", hi, 6);
        checkOutput("burst_busy_len", bz, 18);

        $display("[TB] enable drop mid-burst");
        applyStimulus(1, 2'd3, 6, 2, 3, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("abort_wave", int'(wave), 0);
        checkOutput("abort_busy", int'(busy), 0);
        applyStimulus(1, 2'd2, 10, 3, 0, 0);
        @(negedge clk);
        checkOutput("restart_wave", int'(wave), 1);
        checkOutput("restart_busy", int'(busy), 1);
        repeat (2) @(negedge clk);

        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_wave", int'(wave), 0);
        applyStimulus(0, 2'd0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] illegal configs");
        applyStimulus(1, 2'd1, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("p1_err", int'(cfg_err), 1);
        checkOutput("p1_wave0", int'(wave), 1);
        @(negedge clk);
        checkOutput("p1_err_gap", int'(cfg_err), 0);
        checkOutput("p1_wave1", int'(wave), 0);
        checkOutput("p1_tick", int'(period_tick), 1);
        @(negedge clk);
        checkOutput("p1_err_again", int'(cfg_err), 1);
        applyStimulus(0, 2'd1, 1, 0, 0, 0);
        @(negedge clk);
        applyStimulus(1, 2'd3, 6, 2, 0, 1);
        @(negedge clk);
        checkOutput("bl0_err", int'(cfg_err), 1);
        checkOutput("bl0_busy", int'(busy), 0);
        start = 1'b0;
        @(negedge clk);
        checkOutput("bl0_err_clear", int'(cfg_err), 0);
        checkOutput("bl0_idle", int'(busy), 0);

        repeat (3) @(negedge clk);
        checkOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
